// File: rtl/combi_result_acc_if.sv
// combi_result_acc_if: sample handshake and window-result bundle between
// combi_logic (master side) and combi_result_acc (slave side).
interface combi_result_acc_if #(
    parameter int WIDTH = 8,
    parameter int SUM_W = 10
);
    logic             clear;
    logic             in_valid;
    logic [WIDTH-1:0] result;
    logic             in_ready;
    logic [4:0]       count;
    logic [SUM_W-1:0] sum;
    logic [WIDTH-1:0] avg;
    logic             out_valid;
    logic             overflow;

    modport master (
        output clear, in_valid, result,
        input  in_ready, count, sum, avg, out_valid, overflow
    );

    modport slave (
        input  clear, in_valid, result,
        output in_ready, count, sum, avg, out_valid, overflow
    );
endinterface

// File: rtl/combi_result_acc.sv
// combi_result_acc: windowed accumulator behind combi_logic.
// Sums WINDOW accepted samples, then strobes out_valid for one cycle with the
// sum and truncated average. Sum, count and overflow hold until the next
// window's first accept.
// Optional feature macro: COMBI_ACC_SAT_EN -- when defined the sum saturates at
// 2^SUM_W-1 on carry out; otherwise it wraps. Overflow is flagged either way.
module combi_result_acc #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 4,
    parameter int SUM_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    combi_result_acc_if.slave bus
);
    localparam int               SHIFT   = $clog2(WINDOW);
    localparam logic [4:0]       WIN_CNT = 5'(WINDOW);
    localparam logic [SUM_W-1:0] SUM_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    state_t           state;
    logic [SUM_W-1:0] sum_q;
    logic [4:0]       count_q;
    logic             overflow_q;
    logic             out_valid_q;
    logic             in_ready;
    logic             accept;
    logic [4:0]       count_inc;
    logic [SUM_W:0]   add_res;

    // Add one sample at SUM_W+1 bits; the top bit of the return value is the
    // carry out, the low SUM_W bits are the reduced (wrapped or clamped) sum.
    function automatic logic [SUM_W:0] acc_add(input logic [SUM_W-1:0] acc,
                                               input logic [WIDTH-1:0] x);
        logic [SUM_W:0] wide;
        wide = {1'b0, acc} + {{(SUM_W+1-WIDTH){1'b0}}, x};
`ifdef COMBI_ACC_SAT_EN
        acc_add = wide[SUM_W] ? {1'b1, SUM_MAX} : wide;
`else
        acc_add = wide;
`endif
    endfunction

    assign in_ready  = (state != S_DONE);
    assign accept    = bus.in_valid && in_ready;
    assign count_inc = count_q + 5'd1;
    assign add_res   = acc_add(sum_q, bus.result);

    assign bus.in_ready  = in_ready;
    assign bus.count     = count_q;
    assign bus.sum       = sum_q;
    assign bus.avg       = WIDTH'(sum_q >> SHIFT);
    assign bus.out_valid = out_valid_q;
    assign bus.overflow  = overflow_q;

    // Window FSM: state, accumulator, sample count, sticky overflow and the
    // one-cycle completion strobe all update together on the accepting edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            sum_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (bus.clear) begin
            // Abort wins over a same-cycle sample; that sample is dropped.
            state       <= S_IDLE;
            sum_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    out_valid_q <= 1'b0;
                    if (accept) begin
                        sum_q      <= SUM_W'(bus.result);
                        count_q    <= 5'd1;
                        overflow_q <= 1'b0;
                        if (WIN_CNT == 5'd1) begin
                            state       <= S_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        sum_q      <= add_res[SUM_W-1:0];
                        overflow_q <= overflow_q | add_res[SUM_W];
                        count_q    <= count_inc;
                        if (count_inc == WIN_CNT) begin
                            state       <= S_DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // One bubble with in_ready low; results keep holding.
                    out_valid_q <= 1'b0;
                    state       <= S_IDLE;
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_combi_result_acc.sv
// tb_combi_result_acc: two accumulators (SUM_W=10 and SUM_W=9, WINDOW=4) share
// one stimulus stream; a window-total reference model predicts every output.
module tb_combi_result_acc;
    localparam int WIN = 4;
    localparam int SH  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       v;
    logic       c;
    logic [7:0] x;

    int tests = 0;
    int fails = 0;

    // Reference model: true (unbounded) total of the current window,
    // samples accepted so far, and whether the completion cycle is active.
    int total = 0;
    int n     = 0;
    bit done  = 1'b0;

    combi_result_acc_if #(.WIDTH(8), .SUM_W(10)) ifa ();
    combi_result_acc_if #(.WIDTH(8), .SUM_W(9))  ifb ();

    assign ifa.in_valid = v;
    assign ifa.result   = x;
    assign ifa.clear    = c;
    assign ifb.in_valid = v;
    assign ifb.result   = x;
    assign ifb.clear    = c;

    combi_result_acc #(.WIDTH(8), .WINDOW(WIN), .SUM_W(10)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    combi_result_acc #(.WIDTH(8), .WINDOW(WIN), .SUM_W(9)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    always #5 clk = ~clk;

    function automatic int exp_sum(input int tot, input int sw);
        int m;
        m = 1 << sw;
`ifdef COMBI_ACC_SAT_EN
        return (tot >= m) ? m - 1 : tot;
`else
        return tot % m;
`endif
    endfunction

    function automatic int exp_ovf(input int tot, input int sw);
        return (tot >= (1 << sw)) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        total = 0;
        n     = 0;
        done  = 1'b0;
    endtask

    task automatic model_step(input bit vv, input int xx, input bit cc);
        if (cc) begin
            model_reset();
        end else if (done) begin
            done = 1'b0;
        end else if (vv) begin
            if (n == 0 || n == WIN) begin
                total = xx;
                n     = 1;
            end else begin
                total += xx;
                n++;
            end
            if (n == WIN) done = 1'b1;
        end
    endtask

    task automatic check_all(input string ph);
        int sa;
        int sb;
        sa = exp_sum(total, 10);
        sb = exp_sum(total, 9);
        chk({ph, " a.sum"},   int'(ifa.sum),       sa);
        chk({ph, " a.avg"},   int'(ifa.avg),       (sa >> SH) & 255);
        chk({ph, " a.count"}, int'(ifa.count),     n);
        chk({ph, " a.ovf"},   int'(ifa.overflow),  exp_ovf(total, 10));
        chk({ph, " a.oval"},  int'(ifa.out_valid), int'(done));
        chk({ph, " a.rdy"},   int'(ifa.in_ready),  int'(!done));
        chk({ph, " b.sum"},   int'(ifb.sum),       sb);
        chk({ph, " b.avg"},   int'(ifb.avg),       (sb >> SH) & 255);
        chk({ph, " b.count"}, int'(ifb.count),     n);
        chk({ph, " b.ovf"},   int'(ifb.overflow),  exp_ovf(total, 9));
        chk({ph, " b.oval"},  int'(ifb.out_valid), int'(done));
        chk({ph, " b.rdy"},   int'(ifb.in_ready),  int'(!done));
    endtask

    task automatic step(input bit vv, input int xx, input bit cc, input string ph);
        v = vv;
        x = xx[7:0];
        c = cc;
        @(posedge clk);
        model_step(vv, int'(xx[7:0]), cc);
        #1;
        check_all(ph);
    endtask

    initial begin
        int sat_b;
        sat_b = 508;
`ifdef COMBI_ACC_SAT_EN
        sat_b = 511;
`endif
        // Reset held for 30 time units under random inputs, released on a negedge.
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            v = 1'($urandom);
            x = 8'($urandom);
            c = 1'($urandom);
            #5;
        end
        rst = 1'b1;
        v = 1'b0;
        c = 1'b0;
        x = 8'd0;
        model_reset();
        #1;
        check_all("reset");
        chk("reset.rdy", int'(ifa.in_ready), 1);

        // Basic window, then a sample offered during DONE.
        step(1, 10, 0, "basic1");
        step(1, 20, 0, "basic2");
        step(1, 30, 0, "basic3");
        step(1, 40, 0, "basic4");
        chk("basic.sum",  int'(ifa.sum), 100);
        chk("basic.avg",  int'(ifa.avg), 25);
        chk("basic.cnt",  int'(ifa.count), 4);
        chk("basic.oval", int'(ifa.out_valid), 1);
        step(1, 99, 0, "done_offer");
        chk("done.sum",  int'(ifa.sum), 100);
        chk("done.cnt",  int'(ifa.count), 4);
        chk("done.oval", int'(ifa.out_valid), 0);
        step(1, 99, 0, "after_done");
        chk("after_done.sum", int'(ifa.sum), 99);
        step(0, 0, 1, "clr0");

        // Stall mid-window, then back-to-back next window.
        step(1, 3, 0, "stall1");
        step(1, 3, 0, "stall2");
        for (int i = 0; i < 3; i++) step(0, 55, 0, "stall_gap");
        step(1, 2, 0, "stall3");
        step(1, 2, 0, "stall4");
        chk("stall.sum", int'(ifa.sum), 10);
        chk("stall.avg", int'(ifa.avg), 2);
        step(1, 7, 0, "b2b_done");
        step(1, 7, 0, "b2b_first");
        chk("b2b.sum", int'(ifa.sum), 7);
        chk("b2b.cnt", int'(ifa.count), 1);
        step(0, 0, 1, "clr1");

        // Overflow window.
        for (int i = 0; i < 4; i++) step(1, 255, 0, "ovf");
        chk("ovf.b.sum", int'(ifb.sum), sat_b);
        chk("ovf.b.avg", int'(ifb.avg), 127);
        chk("ovf.b.ovf", int'(ifb.overflow), 1);
        chk("ovf.a.sum", int'(ifa.sum), 1020);
        chk("ovf.a.ovf", int'(ifa.overflow), 0);
        step(0, 0, 0, "ovf_hold");
        chk("ovf_hold.b.ovf", int'(ifb.overflow), 1);

        // Clear beats a same-cycle sample.
        step(0, 0, 1, "clr2");
        step(1, 5, 0, "clr_s1");
        step(1, 6, 0, "clr_s2");
        step(1, 9, 1, "clr_hit");
        chk("clear.sum",  int'(ifa.sum), 0);
        chk("clear.cnt",  int'(ifa.count), 0);
        chk("clear.oval", int'(ifa.out_valid), 0);
        step(0, 0, 0, "clr_after");

        // Asynchronous reset pulse between edges.
        step(1, 1, 0, "ar1");
        step(1, 2, 0, "ar2");
        step(1, 3, 0, "ar3");
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #1;
        rst = 1'b1;
        step(1, 11, 0, "fresh1");
        step(1, 12, 0, "fresh2");
        step(1, 13, 0, "fresh3");
        step(1, 14, 0, "fresh4");
        chk("fresh.sum",  int'(ifa.sum), 50);
        chk("fresh.oval", int'(ifa.out_valid), 1);

        // Randomized traffic with occasional clears and high-valued bursts.
        for (int i = 0; i < 400; i++) begin
            int  val;
            bit  vv;
            bit  cc;
            vv  = ($urandom % 10) < 7;
            cc  = ($urandom % 25) == 0;
            val = ($urandom % 2) ? 200 + int'($urandom % 56) : int'($urandom % 256);
            step(vv, val, cc, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
